sync_2t_wbuf_fifo: RTL

//  Synchronous FIFO on one single_port_RAM with write-side staging: input words

---
 rtl/sync_2t_wbuf_fifo.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sync_2t_wbuf_fifo.sv
// sync_2t_wbuf_fifo: single-port-RAM FIFO with a 4-entry write buffer
// and a 2-entry output stage; reads own the RAM port when they need it.
module sync_2t_wbuf_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 256,
  localparam int LB_FIFO_DEPTH = $clog2(FIFO_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   clear,
  output logic [LB_FIFO_DEPTH:0] count
);

  localparam int LB = LB_FIFO_DEPTH;
  localparam logic [LB:0] FULL_CNT = FIFO_DEPTH[LB:0];

  logic [DATA_WIDTH-1:0] wbuf [4];
  logic [1:0]            wb_rp;
  logic [1:0]            wb_wp;
  logic [2:0]            wb_cnt;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [LB-1:0]         waddr;
  logic [LB-1:0]         raddr;
  logic [LB:0]           mem_count;
  logic [DATA_WIDTH-1:0] dout;
  logic                  rd_inflight;

  logic [DATA_WIDTH-1:0] ostg [2];
  logic                  os_rp;
  logic                  os_wp;
  logic [1:0]            os_cnt;

  logic flush;
  logic in_exec;
  logic out_exec;
  logic rd_exec;
  logic wr_exec;
  logic [LB+1:0] inv_sum;

  assign flush     = !rstn | clear;
  assign in_ready  = (count < FULL_CNT) & (wb_cnt < 3'd4);
  assign out_valid = (os_cnt != 2'd0);
  assign out_data  = ostg[os_rp];
  assign in_exec   = in_valid & in_ready;
  assign out_exec  = out_valid & out_ready;

  // A read is only issued when its word is guaranteed a slot in the out stage
  assign rd_exec = (mem_count != '0)
                 & ((os_cnt + {1'b0, rd_inflight}) < 2'd2);
  assign wr_exec = !rd_exec & (wb_cnt != 3'd0);

  assign inv_sum = (LB+2)'(wb_cnt) + {1'b0, mem_count}
                 + (LB+2)'(rd_inflight) + (LB+2)'(os_cnt);

  // Total occupancy: moves only on the external handshakes
  always_ff @(posedge clk) begin
    if (flush) begin
      count <= '0;
    end else if (in_exec & !out_exec) begin
      count <= count + 1'b1;
    end else if (out_exec & !in_exec) begin
      count <= count - 1'b1;
    end
  end

  // Write buffer: push accepted words, pop on each RAM write
  always_ff @(posedge clk) begin
    if (flush) begin
      wb_rp  <= '0;
      wb_wp  <= '0;
      wb_cnt <= '0;
    end else begin
      if (in_exec) begin
        wbuf[wb_wp] <= in_data;
        wb_wp       <= wb_wp + 2'd1;
      end
      if (wr_exec) begin
        wb_rp <= wb_rp + 2'd1;
      end
      wb_cnt <= wb_cnt + {2'b0, in_exec} - {2'b0, wr_exec};
    end
  end

  // Single RAM port: either one write or one read per cycle
  always_ff @(posedge clk) begin
    if (wr_exec) begin
      mem[waddr] <= wbuf[wb_rp];
    end
    if (rd_exec) begin
      dout <= mem[raddr];
    end
  end

  // RAM pointers, occupancy and read-in-flight tracking
  always_ff @(posedge clk) begin
    if (flush) begin
      waddr       <= '0;
      raddr       <= '0;
      mem_count   <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (rd_exec) begin
        raddr <= raddr + 1'b1;
      end
      if (wr_exec) begin
        waddr <= waddr + 1'b1;
      end
      mem_count <= mem_count + {{LB{1'b0}}, wr_exec}
                             - {{LB{1'b0}}, rd_exec};
      rd_inflight <= rd_exec;
    end
  end

  // Output stage: capture RAM data one cycle after a read, pop on out_exec
  always_ff @(posedge clk) begin
    if (flush) begin
      os_rp  <= 1'b0;
      os_wp  <= 1'b0;
      os_cnt <= '0;
    end else begin
      if (rd_inflight) begin
        ostg[os_wp] <= dout;
        os_wp       <= ~os_wp;
      end
      if (out_exec) begin
        os_rp <= ~os_rp;
      end
      os_cnt <= os_cnt + {1'b0, rd_inflight} - {1'b0, out_exec};
    end
  end

  // Every word is accounted for in exactly one place
  always_ff @(posedge clk) begin
    if (!flush) begin
      assert ({1'b0, count} == inv_sum);
    end
  end

endmodule
